// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/add/shift ops, iterative MUL and DIV.
// Optional carry/overflow/negative outputs when ALU_SEQ_FLAGS_EN is defined.
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int CTRL_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [CTRL_W-1:0] alu_control,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero_flag,
  output logic              div_by_zero
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic              carry_flag,
  output logic              overflow_flag,
  output logic              negative_flag
`endif
);

  localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(5'b00001);
  localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(5'b00010);
  localparam logic [CTRL_W-1:0] OP_ADDI = CTRL_W'(5'b00011);
  localparam logic [CTRL_W-1:0] OP_MUL  = CTRL_W'(5'b00100);
  localparam logic [CTRL_W-1:0] OP_DIV  = CTRL_W'(5'b00101);
  localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(5'b00110);
  localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(5'b00111);
  localparam logic [CTRL_W-1:0] OP_XOR  = CTRL_W'(5'b01000);
  localparam logic [CTRL_W-1:0] OP_XORI = CTRL_W'(5'b01001);
  localparam logic [CTRL_W-1:0] OP_SLL  = CTRL_W'(5'b01010);
  localparam logic [CTRL_W-1:0] OP_SRL  = CTRL_W'(5'b01011);
  localparam logic [CTRL_W-1:0] OP_SRA  = CTRL_W'(5'b01100);
  localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(5'b10100);

  localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state;

  // Iteration registers: opa is multiplicand / dividend-quotient,
  // opb is multiplier / divisor, acc is product / partial remainder.
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [SHAMT_W-1:0] cnt;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   dif;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   comb_res;
  logic               is_mul;
  logic               is_div;
  logic               b_zero;

  logic [WIDTH-1:0]   mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic               last;

`ifdef ALU_SEQ_FLAGS_EN
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     dif_ext;
  logic               comb_carry;
  logic               comb_ovf;
  logic               msb_a;
  logic               msb_b;

  assign sum_ext = {1'b0, operand_a} + {1'b0, operand_b};
  assign dif_ext = {1'b0, operand_a} - {1'b0, operand_b};
  assign sum     = sum_ext[WIDTH-1:0];
  assign dif     = dif_ext[WIDTH-1:0];
  assign msb_a   = operand_a[WIDTH-1];
  assign msb_b   = operand_b[WIDTH-1];

  // Carry/borrow and signed overflow only mean something for add/sub
  always_comb begin
    comb_carry = 1'b0;
    comb_ovf   = 1'b0;
    if (alu_control == OP_ADD || alu_control == OP_ADDI) begin
      comb_carry = sum_ext[WIDTH];
      comb_ovf   = (msb_a == msb_b) && (sum[WIDTH-1] != msb_a);
    end else if (alu_control == OP_SUB) begin
      comb_carry = dif_ext[WIDTH];
      comb_ovf   = (msb_a != msb_b) && (dif[WIDTH-1] != msb_a);
    end
  end
`else
  assign sum = operand_a + operand_b;
  assign dif = operand_a - operand_b;
`endif

  assign shamt  = operand_b[SHAMT_W-1:0];
  assign is_mul = (alu_control == OP_MUL);
  assign is_div = (alu_control == OP_DIV);
  assign b_zero = (operand_b == '0);

  assign in_ready = (state == S_IDLE) && !reset;

  // Single-cycle result; DIV only lands here when the divisor is zero
  always_comb begin
    comb_res = '0;
    unique case (alu_control)
      OP_ADD,
      OP_ADDI: comb_res = sum;
      OP_SUB:  comb_res = dif;
      OP_DIV:  comb_res = '1;
      OP_AND:  comb_res = operand_a & operand_b;
      OP_OR:   comb_res = operand_a | operand_b;
      OP_XOR,
      OP_XORI: comb_res = operand_a ^ operand_b;
      OP_SLL:  comb_res = operand_a << shamt;
      OP_SRL:  comb_res = operand_a >> shamt;
      OP_SRA:  comb_res = $signed(operand_a) >>> shamt;
      OP_SLT:  comb_res = {{(WIDTH-1){1'b0}},
                           $signed(operand_a) < $signed(operand_b)};
      default: comb_res = '0;
    endcase
  end

  // One shift-add step and one restoring-division step per cycle
  always_comb begin
    mul_next = acc + (opb[0] ? opa : '0);
    rem_sh   = {acc, opa[WIDTH-1]};
    rem_sub  = rem_sh - {1'b0, opb};
    rem_ge   = (rem_sh >= {1'b0, opb});
    rem_next = WIDTH'(rem_ge ? rem_sub : rem_sh);
    quo_next = {opa[WIDTH-2:0], rem_ge};
    last     = (cnt == LAST);
  end

  // Control FSM, iterative datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      result      <= '0;
      zero_flag   <= 1'b0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
      acc         <= '0;
      opa         <= '0;
      opb         <= '0;
      cnt         <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      negative_flag <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            div_by_zero <= 1'b0;
            acc         <= '0;
            opa         <= operand_a;
            opb         <= operand_b;
            cnt         <= '0;
            if (is_mul) begin
              state <= S_MUL;
            end else if (is_div && !b_zero) begin
              state <= S_DIV;
            end else begin
              result      <= comb_res;
              zero_flag   <= (comb_res == '0);
              div_by_zero <= is_div;
              out_valid   <= 1'b1;
              state       <= S_DONE;
`ifdef ALU_SEQ_FLAGS_EN
              carry_flag    <= comb_carry;
              overflow_flag <= comb_ovf;
              negative_flag <= comb_res[WIDTH-1];
`endif
            end
          end
        end
        S_MUL: begin
          acc <= mul_next;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt + 1'b1;
          if (last) begin
            result    <= mul_next;
            zero_flag <= (mul_next == '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
`ifdef ALU_SEQ_FLAGS_EN
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            negative_flag <= mul_next[WIDTH-1];
`endif
          end
        end
        S_DIV: begin
          acc <= rem_next;
          opa <= quo_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            result    <= quo_next;
            zero_flag <= (quo_next == '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
`ifdef ALU_SEQ_FLAGS_EN
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            negative_flag <= quo_next[WIDTH-1];
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq.
// Flag outputs are checked when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_seq;

  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b00011;
  localparam logic [4:0] OP_MUL  = 5'b00100;
  localparam logic [4:0] OP_DIV  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_XOR  = 5'b01000;
  localparam logic [4:0] OP_XORI = 5'b01001;
  localparam logic [4:0] OP_SLL  = 5'b01010;
  localparam logic [4:0] OP_SRL  = 5'b01011;
  localparam logic [4:0] OP_SRA  = 5'b01100;
  localparam logic [4:0] OP_SLT  = 5'b10100;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero_flag;
  logic        div_by_zero;
`ifdef ALU_SEQ_FLAGS_EN
  logic        carry_flag;
  logic        overflow_flag;
  logic        negative_flag;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(32), .SHAMT_W(5), .CTRL_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero_flag   (zero_flag),
    .div_by_zero (div_by_zero)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .negative_flag (negative_flag)
`endif
  );

  always #5 clk = ~clk;

  // Issue one op once in_ready; lat=1 means out_valid right after accept
  task automatic do_op(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat,
                       output bit busy_rdy);
    int guard;
    guard = 0;
    busy_rdy = 1'b0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    alu_control = op;
    operand_a = a;
    operand_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    operand_a = 32'hDEAD_BEEF;
    operand_b = 32'h1234_5678;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_rdy = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    operand_a = '0;
    operand_b = '0;
    alu_control = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_in_ready got %b want 0", in_ready);
    end
    n_cmp++;
    if ({out_valid, result, zero_flag, div_by_zero} !== 35'h0) begin
      n_bad++;
      $display("FAIL rst_outputs got v=%b r=%h z=%b d=%b want all 0",
               out_valid, result, zero_flag, div_by_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_add_wrap();
    int lat;
    bit br;
    do_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, lat, br);
    n_cmp++;
    if (lat !== 1) begin
      n_bad++;
      $display("FAIL add_latency got %0d want 1", lat);
    end
    n_cmp++;
    if (result !== 32'h0 || zero_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL add_wrap got r=%h z=%b want r=0 z=1",
               result, zero_flag);
    end
`ifdef ALU_SEQ_FLAGS_EN
    n_cmp++;
    if ({carry_flag, overflow_flag, negative_flag} !== 3'b100) begin
      n_bad++;
      $display("FAIL add_flags got c/o/n=%b%b%b want 100",
               carry_flag, overflow_flag, negative_flag);
    end
`endif
  endtask

  task automatic test_single_ops();
    logic [4:0]  ops [12];
    logic [31:0] as  [12];
    logic [31:0] bs  [12];
    logic [31:0] exp [12];
    int lat;
    bit br;
    ops = '{OP_ADDI, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_XORI,
            OP_SLL, OP_SRA, OP_SRL, OP_SLT, OP_SLT, 5'b11111};
    as  = '{32'h7FFF_FFFF, 32'h0, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
            32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h1, 32'h8000_0000,
            32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h3};
    bs  = '{32'h1, 32'h1, 32'hFF00_FF00, 32'hFF00_FF00,
            32'hFF00_FF00, 32'hFF00_FF00, 32'h3F, 32'h24,
            32'h24, 32'h1, 32'hFFFF_FFFF, 32'h4};
    exp = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hF000_F000, 32'hFFF0_FFF0,
            32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h8000_0000, 32'hF800_0000,
            32'h0800_0000, 32'h1, 32'h0, 32'h0};
    for (int i = 0; i < 12; i++) begin
      do_op(ops[i], as[i], bs[i], lat, br);
      n_cmp++;
      if (result !== exp[i] || zero_flag !== (exp[i] == 32'h0)
          || lat !== 1) begin
        n_bad++;
        $display("FAIL single_op[%0d] op=%b got r=%h z=%b lat=%0d want r=%h lat=1",
                 i, ops[i], result, zero_flag, lat, exp[i]);
      end
`ifdef ALU_SEQ_FLAGS_EN
      if (i == 0) begin
        n_cmp++;
        if ({carry_flag, overflow_flag, negative_flag} !== 3'b011) begin
          n_bad++;
          $display("FAIL addi_flags got c/o/n=%b%b%b want 011",
                   carry_flag, overflow_flag, negative_flag);
        end
      end
      if (i == 1) begin
        n_cmp++;
        if ({carry_flag, overflow_flag, negative_flag} !== 3'b101) begin
          n_bad++;
          $display("FAIL sub_flags got c/o/n=%b%b%b want 101",
                   carry_flag, overflow_flag, negative_flag);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if ({carry_flag, overflow_flag, negative_flag} !== 3'b001) begin
          n_bad++;
          $display("FAIL and_flags got c/o/n=%b%b%b want 001",
                   carry_flag, overflow_flag, negative_flag);
        end
      end
`endif
    end
  endtask

  task automatic test_mul();
    int lat;
    bit br;
    do_op(OP_MUL, 32'd12345, 32'd6789, lat, br);
    n_cmp++;
    if (lat !== 33 || br !== 1'b0) begin
      n_bad++;
      $display("FAIL mul_timing got lat=%0d ready_while_busy=%b want 33/0",
               lat, br);
    end
    n_cmp++;
    if (result !== 32'd83810205) begin
      n_bad++;
      $display("FAIL mul_result got %0d want 83810205", result);
    end
    do_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, br);
    n_cmp++;
    if (result !== 32'h1 || zero_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL mul_neg got r=%h z=%b want 1/0", result, zero_flag);
    end
    do_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, lat, br);
    n_cmp++;
    if (result !== 32'h0 || zero_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL mul_wrap got r=%h z=%b want 0/1", result, zero_flag);
    end
  endtask

  task automatic test_stall();
    int lat;
    bit br;
    int bad_cycles;
    out_ready = 1'b0;
    do_op(OP_SUB, 32'd5, 32'd5, lat, br);
    bad_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || result !== 32'h0 || zero_flag !== 1'b1
          || in_ready !== 1'b0) bad_cycles++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bad_cycles !== 0 || lat !== 1) begin
      n_bad++;
      $display("FAIL stall_hold got %0d unstable cycles lat=%0d want 0/1",
               bad_cycles, lat);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_release got v=%b rdy=%b want 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_div();
    int lat;
    bit br;
    do_op(OP_DIV, 32'd100, 32'd7, lat, br);
    n_cmp++;
    if (lat !== 33 || br !== 1'b0) begin
      n_bad++;
      $display("FAIL div_timing got lat=%0d ready_while_busy=%b want 33/0",
               lat, br);
    end
    n_cmp++;
    if (result !== 32'd14 || div_by_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL div_result got r=%0d dbz=%b want 14/0",
               result, div_by_zero);
    end
    do_op(OP_DIV, 32'hFFFF_FFFF, 32'h10, lat, br);
    n_cmp++;
    if (result !== 32'h0FFF_FFFF) begin
      n_bad++;
      $display("FAIL div_big got %h want 0fffffff", result);
    end
    do_op(OP_DIV, 32'd3, 32'd5, lat, br);
    n_cmp++;
    if (result !== 32'h0 || zero_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL div_small got r=%h z=%b want 0/1", result, zero_flag);
    end
    do_op(OP_DIV, 32'd5, 32'd0, lat, br);
    n_cmp++;
    if (result !== 32'hFFFF_FFFF || div_by_zero !== 1'b1 || lat !== 1) begin
      n_bad++;
      $display("FAIL div_zero got r=%h dbz=%b lat=%0d want ffffffff/1/1",
               result, div_by_zero, lat);
    end
    do_op(OP_ADD, 32'd2, 32'd3, lat, br);
    n_cmp++;
    if (result !== 32'd5 || div_by_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL dbz_clear got r=%h dbz=%b want 5/0",
               result, div_by_zero);
    end
    do_op(OP_DIV, 32'd9, 32'd0, lat, br);
  endtask

  task automatic test_reset_mid_div();
    int guard;
    int seen;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    alu_control = OP_DIV;
    operand_a = 32'd1000;
    operand_b = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_in_reset got rdy=%b v=%b want 0/0",
               in_ready, out_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || result !== 32'h0 || zero_flag !== 1'b0
        || div_by_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_state got rdy=%b r=%h z=%b d=%b want 1/0/0/0",
               in_ready, result, zero_flag, div_by_zero);
    end
`ifdef ALU_SEQ_FLAGS_EN
    n_cmp++;
    if ({carry_flag, overflow_flag, negative_flag} !== 3'b000) begin
      n_bad++;
      $display("FAIL abort_flags got c/o/n=%b%b%b want 000",
               carry_flag, overflow_flag, negative_flag);
    end
`endif
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL abort_no_valid got %0d valid cycles want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_single_ops();
    test_mul();
    test_stall();
    test_div();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the processor's combinational ALU. Same operation codes.
- Operand width is generic. MUL and DIV run on iterative shift-add and restoring datapaths, replacing the wide combinational `*` and `/`.
- Operands and results move on valid/ready handshakes, so the execute stage can stall on long operations.
- Sits between the register-read/operand-mux stage and writeback.

Parameters:
- WIDTH, 32, operand/result width in bits (≥ 8, power of two).
- SHAMT_W, 5, shift-amount bits taken from operand_b; must equal log2(WIDTH).
- CTRL_W, 5, width of alu_control.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands and alu_control valid
- in_ready  output  1  block can accept an operation
- operand_a  input  WIDTH  first operand
- operand_b  input  WIDTH  second operand / shift amount
- alu_control  input  CTRL_W  operation code
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes the result
- result  output  WIDTH  registered result
- zero_flag  output  1  registered (result == 0)
- div_by_zero  output  1  set with result when DIV had operand_b == 0

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE; result=0; zero_flag=0; div_by_zero=0; out_valid=0; internal accumulators=0.
- in_ready = (state==IDLE) && !reset. It is combinational, and is 0 during the reset cycle.
- Opcodes:
  - ADD 00001, ADDI 00011 → a+b
  - SUB 00010 → a−b
  - MUL 00100, DIV 00101
  - AND 00110, OR 00111, XOR 01000, XORI 01001
  - SLL 01010, SRL 01011, SRA 01100 (arithmetic)
  - SLT 10100 (signed compare → 1/0)
  - Any other code → result 0.
- Arithmetic wraps modulo 2^WIDTH. Shifts use operand_b[SHAMT_W-1:0] only.
- Accept: in_valid && in_ready on a rising edge. Operands and opcode are captured on that edge; inputs are don't-care afterwards.
- States:
  - IDLE
    - Single-cycle op → compute, register result and flags, go to DONE.
    - MUL → go to MUL.
    - DIV with b≠0 → go to DIV.
    - DIV with b==0 → result={WIDTH{1}}, div_by_zero=1, go to DONE.
  - MUL: unsigned shift-add, one multiplier bit per cycle, WIDTH cycles, then DONE. Result is the low WIDTH bits of the product (same as signed low half).
  - DIV: unsigned restoring division, one quotient bit per cycle, WIDTH cycles, then DONE. Result is the quotient.
  - DONE: out_valid=1. result, zero_flag and div_by_zero are stable. On out_ready → IDLE and out_valid drops next cycle.
- Latency, accept edge to out_valid high:
  - Single-cycle ops and DIV-by-zero: 1 cycle.
  - MUL/DIV: WIDTH+1 cycles.
- Throughput: one operation in flight. No accept while busy or in DONE, so there is no back-to-back overlap. A new accept is possible the cycle after the out_ready handshake.
- div_by_zero is cleared on every accept. It is only meaningful while out_valid=1.
- out_ready held low: DONE holds indefinitely and outputs do not change.
- reset asserted in any state, including mid-MUL/DIV: the operation is aborted, no out_valid is produced, and all state returns to reset values on that edge.

Optional Feature:
- Macro ALU_SEQ_FLAGS_EN.
- Defined: adds outputs carry_flag, overflow_flag and negative_flag (1 bit each), registered with result and reset to 0.
  - carry: ADD/ADDI carry-out; SUB borrow (a<b unsigned).
  - overflow: signed overflow for ADD/ADDI/SUB.
  - negative: result[WIDTH-1] for every op.
  - carry and overflow are 0 for all ops other than ADD/ADDI/SUB.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

Test Plan:
- ADD a=0xFFFFFFFF, b=1, out_ready=1 → out_valid 1 cycle after accept, result=0, zero_flag=1. With ALU_SEQ_FLAGS_EN: carry=1, overflow=0.
- MUL a=12345, b=6789 → out_valid exactly 33 cycles after accept, result=83810205, in_ready=0 throughout.
- DIV a=100, b=7 → result=14 at cycle 33. Then DIV a=5, b=0 → result=0xFFFFFFFF, div_by_zero=1, latency 1.
- SRA a=0x80000000, b=0x24 (shamt 4) → result=0xF8000000. SRL same operands → 0x08000000. SLT a=-1, b=1 → 1.
- out_ready held 0 for 10 cycles after a SUB 5−5 → out_valid, result=0 and zero_flag=1 stable, in_ready=0. Release out_ready → out_valid drops next cycle and in_ready returns to 1.
- Assert reset at cycle 10 of a DIV → no out_valid ever. The cycle after reset deasserts: in_ready=1, result=0, flags=0.
